// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the data-memory responder (slave).
// Requests use valid/ready; the response is a single-cycle pulse, and stall is the pipeline freeze request.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data store answering one load/store at a time; response pulse LATENCY cycles after acceptance.
// No queueing: req_ready is low from acceptance through the response cycle, and stall holds the pipeline meanwhile.
module data_mem_responder #(
   parameter int  DEPTH   = 256,
   parameter int  LATENCY = 2,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 startin,
   data_mem_responder_if.slave  bus,
   input  logic [IDX_W-1:0]     dbg_idx,
   output logic [31:0]          dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rdy_q, rdy_d;
   logic        rsp_vld_q, rsp_vld_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH];

   logic [29:0]      word_idx;
   logic [IDX_W-1:0] widx;
   logic             acc_err;
   logic             mem_we;

   // Range check is done on the full 30-bit word index so aliasing addresses fault instead of wrapping.
   assign word_idx = addr_q[31:2];
   assign widx     = word_idx[IDX_W-1:0];
   assign acc_err  = (addr_q[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdy_d     = rdy_q;
      rsp_vld_d = rsp_vld_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      mem_we    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && rdy_q) begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rdy_d   = 1'b0;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d   = RESP;
               rsp_vld_d = 1'b1;
               err_d     = acc_err;
               rdata_d   = (wr_q || acc_err) ? 32'd0 : mem_q[widx];
               mem_we    = wr_q && !acc_err;
            end
         end
         RESP: begin
            state_d   = IDLE;
            rsp_vld_d = 1'b0;
            rdy_d     = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            rsp_vld_d = 1'b0;
            rdy_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         wr_q      <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rdy_q     <= 1'b1;
         rsp_vld_q <= 1'b0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdy_q     <= rdy_d;
         rsp_vld_q <= rsp_vld_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // The whole store clears on reset, so an aborted store can never leave a partial commit behind.
   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (mem_we) begin
         mem_q[widx] <= wdata_q;
      end
   end

   // RESP leaves stall low so the pipeline advances on the same edge the FSM returns to IDLE.
   assign bus.stall     = (state_q == WAIT) || ((state_q == IDLE) && bus.req_valid);
   assign bus.req_ready = rdy_q;
   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign dbg_data      = mem_q[dbg_idx];

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready handshake. It holds a word-addressed data store and returns read data or write completion after a fixed, parameterised latency. It generates a `stall` signal that the pipeline uses to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding. A combinational debug port exposes any stored word to the testbench.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words in the store; power of two, 4..4096.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..16.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `startin`  in  1  asynchronous, active-low reset; asserting it clears all state and the entire store.
- `req_valid`  in  1  MEM stage presents a load or store.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; word index = `req_addr[31:2]`.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  one-cycle pulse: access complete.
- `rsp_rdata`  out  32  load data, valid while `rsp_valid`.
- `rsp_err`  out  1  access faulted, valid while `rsp_valid`.
- `stall`  out  1  pipeline hold request.
- `dbg_idx`  in  clog2(DEPTH)  debug word index.
- `dbg_data`  out  32  combinational `store[dbg_idx]`.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready`=1.
    - Handshake (`req_valid & req_ready`) at a rising edge latches `req_write`, `req_addr` and `req_wdata`, loads the counter with `LATENCY-1`, and moves to WAIT.
  - WAIT: `req_ready`=0.
    - Counter ≠ 0: decrement.
    - Counter = 0: perform the access, register the result, and move to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=0; the next edge always returns to IDLE.
- Fault detection: a request faults if `addr[1:0]` ≠ 0 or `addr[31:2]` ≥ DEPTH.
- Access:
  - Load: `rsp_rdata` = `store[idx]`.
  - Store: `store[idx]` = `wdata`; `rsp_rdata` = 0.
  - Faulted access: the store is not modified, `rsp_rdata` = 0, `rsp_err` = 1.
- `rsp_rdata` and `rsp_err` are registered and hold their values until the next access completes.
- Stall logic:
  - `stall` = (state == WAIT) | (state == IDLE & `req_valid`).
  - `stall` is 0 in RESP, so the pipeline advances on the same edge that leaves RESP.
  - `stall` is 0 in IDLE when `req_valid`=0 (ALU and nop instructions are never stalled).
- Requests in WAIT or RESP are ignored, not queued. The requester holds `req_valid` and its fields until it observes `rsp_valid`.
- Counter width is 4 bits.
- Word index arithmetic uses `addr[31:2]` compared against DEPTH in full width, with no truncation before the compare.
- `dbg_data` reflects a store update from the cycle after the commit edge onward.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0, all store words 0. During reset, `stall` follows `req_valid`.
- Latency: for a handshake at edge k, the store commits at edge k+LATENCY. `rsp_valid` is high during the cycle between edges k+LATENCY and k+LATENCY+1.
- Throughput: at most one access per LATENCY+2 cycles. The next acceptance happens at the earliest at edge k+LATENCY+2.
- With LATENCY=1, WAIT lasts exactly one cycle.
- Read-after-write to the same address returns the new value.
- Reset asserted mid-access: the transaction is aborted, no store commit occurs, `rsp_valid` stays 0, and the FSM is in IDLE as soon as reset asserts.
- `req_valid` dropping during WAIT does not cancel the access; it completes normally.

## Test plan
- Reset then idle:
  - Stimulus: `startin` low for 2 cycles, then high, with `req_valid`=0.
  - Required: `req_ready`=1, `rsp_valid`=0, `stall`=0, `dbg_data`=0 for `dbg_idx` 0 and DEPTH-1.
- Store then load, LATENCY=2:
  - Stimulus: store 0xDEADBEEF to address 0x10, then load from address 0x10.
  - Required for the store: `rsp_valid` pulses 2 cycles after acceptance with `rsp_err`=0; `dbg_idx`=4 reads 0xDEADBEEF the following cycle.
  - Required for the load: `rsp_rdata`=0xDEADBEEF; `stall` is high for exactly 3 cycles per access.
- Faults:
  - Stimulus: store to address 0x13 (misaligned), and store to address 4·DEPTH (out of range).
  - Required: `rsp_err`=1 and `rsp_rdata`=0 for both; store contents unchanged, checked via `dbg_data`.
- Held request:
  - Stimulus: keep `req_valid`=1 continuously with changing addresses 0x0, 0x4, 0x8.
  - Required: exactly one acceptance per LATENCY+2 cycles; fields presented during WAIT or RESP are not latched.
- Reset mid-access:
  - Stimulus: store 0x1234 to address 0x8, then assert `startin` low during WAIT.
  - Required: no `rsp_valid` pulse; `store[2]`=0; after release the FSM is in IDLE with `req_ready`=1.
- LATENCY=1 build:
  - Stimulus: load from address 0.
  - Required: `rsp_valid` is high during the cycle after the edge following acceptance, with `rsp_rdata`=0.
